sine_sequencer: RTL and testbench
=================================

SINE_SEQUENCER -- requirements
Module: sine_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning sample/ROM data width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning ROM entries; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter PHASE_W, default 16, meaning phase accumulator width; PHASE_W >= AW.
REQ-004 SHALL have clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have start  input  1  pulse: begin playback from phase 0.
REQ-007 SHALL have stop  input  1  pulse: end playback.
REQ-008 SHALL have tick  input  1  sample-rate enable, one sample request per asserted cycle.
REQ-009 SHALL have step  input  PHASE_W  phase increment (tuning word), sampled at start.
REQ-010 SHALL have rom_en  output  1  ROM read enable.
REQ-011 SHALL have rom_addr  output  AW  ROM read address.
REQ-012 SHALL have rom_data  input  WIDTH  ROM read data, valid one cycle after rom_en.
REQ-013 SHALL have sample_data  output  WIDTH  registered sample.
REQ-014 SHALL have sample_valid  output  1  sample_data holds an unconsumed sample.
REQ-015 SHALL have sample_ready  input  1  consumer accepts sample when high with sample_valid.
REQ-016 SHALL have busy  output  1  high in RUN or while a read is pending.
REQ-017 SHALL have overrun  output  1  sticky: a tick was dropped.

Function
REQ-018 SHALL implement states IDLE and RUN; plus a 1-bit pending flag tracking an outstanding ROM read.
REQ-019 IDLE->RUN on start; on that edge phase <= 0, step_q <= step, overrun <= 0.
REQ-020 RUN->IDLE on stop; stop wins if start and stop coincide; start in RUN restarts (phase <= 0, step_q <= step).
REQ-021 Issue condition: state RUN, tick=1, stop=0, pending=0, and (sample_valid=0 or sample_ready=1).
REQ-022 On issue: rom_en=1 combinationally, rom_addr = phase[PHASE_W-1 -: AW], phase <= phase + step_q mod 2^PHASE_W (wrap, no saturation), pending <= 1.
REQ-023 rom_en SHALL be 0 in every non-issue cycle; rom_addr SHALL hold phase top bits regardless.
REQ-024 Cycle after issue: sample_data <= rom_data, sample_valid <= 1, pending <= 0; read-to-valid latency exactly 1 cycle after rom_en.
REQ-025 sample_valid SHALL clear on handshake (valid & ready) unless refilled the same cycle.
REQ-026 tick in RUN failing REQ-021 (stalled output or pending read) SHALL set overrun; phase does not advance.
REQ-027 stop with a pending read: pending read SHALL complete and deliver its sample; busy drops after.
REQ-028 A held sample SHALL remain stable until accepted, in any state.
REQ-029 tick in IDLE SHALL be ignored, no overrun.

Reset
REQ-030 rst SHALL set state IDLE, phase 0, step_q 0, pending 0, sample_data 0, sample_valid 0, overrun 0, busy 0; rom_en 0.
REQ-031 rst SHALL override all inputs, including mid-playback and with a pending read (the read is discarded).

Verification
REQ-032 DEPTH=64, PHASE_W=16, step=0x0400, start, tick every cycle, ready=1 -> rom_addr 0,1,2,...,63,0 on consecutive issues, sample_valid one cycle after each rom_en.
REQ-033 step=0xC000, 5 ticks -> addresses 0,48,32,16,0 (wrap-around).
REQ-034 ready=0 after first sample, 3 further ticks -> no rom_en, sample_data stable, overrun=1; ready=1 -> accepted, next tick issues.
REQ-035 start and stop same cycle from IDLE -> stays IDLE, busy=0, rom_en never asserted.
REQ-036 stop in the issue cycle's successor (pending=1) -> sample delivered next cycle, busy=0 after; rst during RUN with pending -> all outputs at reset values next cycle, no sample_valid.

Source files
------------

// File: rtl/sine_sequencer.sv
// Phase-accumulator sine player: one ROM read per accepted tick, sample registered 1 cycle after rom_en.
// Ticks are dropped (sticky overrun) while a read is pending or an unaccepted sample is held.
module sine_sequencer #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 64,
  parameter int PHASE_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  input  logic [PHASE_W-1:0] step,
  output logic               rom_en,
  output logic [AW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]   rom_data,
  output logic [WIDTH-1:0]   sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] step_q;
  logic               pending;
  logic               issue;
  logic               drop;

  // A tick is only honoured when the output slot will be free by the time the read lands.
  assign issue    = (state == RUN) && tick && !stop && !pending &&
                    (!sample_valid || sample_ready);
  assign drop     = (state == RUN) && tick && !stop && !issue;
  assign rom_addr = phase[PHASE_W-1 -: AW];
  assign busy     = (state == RUN) || pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    rom_en = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      step_q       <= '0;
      pending      <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      pending <= issue;

      if (pending) begin
        sample_data  <= rom_data;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      // A (re)start overrides the advance made by a coincident issue.
      if (start && !stop) begin
        phase  <= '0;
        step_q <= step;
      end else if (issue) begin
        phase <= phase + step_q;
      end

      if (start && !stop && (state == IDLE)) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sine_sequencer.sv
// Self-checking bench for sine_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_sine_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] step = 16'h0;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data = 64'h0;
  logic [63:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [63:0] rom [64];

  sine_sequencer #(.WIDTH(64), .DEPTH(64), .PHASE_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .tick         (tick),
    .step         (step),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  // Reference model: playback flag, phase, FIFO of in-flight read addresses, single output slot.
  bit          m_run = 0;
  logic [15:0] m_phase = 16'h0;
  logic [15:0] m_step = 16'h0;
  logic [5:0]  m_flight[$];
  bit          m_valid = 0;
  logic [63:0] m_data = 64'h0;
  bit          m_ovr = 0;

  function automatic bit m_issue();
    return m_run && tick && !stop && (m_flight.size() == 0) && (!m_valid || sample_ready);
  endfunction

  function automatic logic [73:0] exp_vec();
    bit b;
    b = m_run || (m_flight.size() != 0);
    return {m_issue(), m_phase[15:10], m_valid, m_data, b, m_ovr};
  endfunction

  function automatic logic [73:0] obs_vec();
    return {rom_en, rom_addr, sample_valid, sample_data, busy, overrun};
  endfunction

  always @(posedge clk) begin
    bit iss, drp;
    if (rst) begin
      m_run = 0; m_phase = 0; m_step = 0; m_flight.delete();
      m_valid = 0; m_data = 0; m_ovr = 0;
    end else begin
      iss = m_issue();
      drp = m_run && tick && !stop && !iss;
      if (m_flight.size() != 0) begin
        m_data  = rom[m_flight.pop_front()];
        m_valid = 1;
      end else if (m_valid && sample_ready) begin
        m_valid = 0;
      end
      if (iss) begin
        m_flight.push_back(m_phase[15:10]);
        m_phase = m_phase + m_step;
      end
      if (drp) m_ovr = 1;
      if (stop) m_run = 0;
      else if (start) begin
        if (!m_run) m_ovr = 0;
        m_run = 1; m_phase = 0; m_step = step;
      end
    end
  end

  task automatic drv(input bit r, input bit s, input bit p, input bit t, input bit rdy);
    @(negedge clk);
    rst = r; start = s; stop = p; tick = t; sample_ready = rdy;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 0, 1);
  endtask

  task automatic test_reset();
    drv(1, 0, 0, 0, 1);
    drv(1, 1, 0, 1, 1);
    checks++;
    if (obs_vec() !== 74'd0) begin
      errors++; $display("FAIL reset_state: got %h want 0", obs_vec());
    end
    drv(0, 0, 0, 1, 1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle_tick: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sweep();
    int n = 0;
    step = 16'h0400;
    drv(0, 1, 0, 0, 1);
    for (int c = 0; c < 140; c++) begin
      drv(0, 0, 0, 1, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL sweep_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (rom_en) begin
        checks++;
        if (rom_addr !== 6'(n % 64)) begin
          errors++; $display("FAIL sweep_addr %0d: got %0d want %0d", n, rom_addr, n % 64);
        end
        n++;
      end
    end
    checks++;
    if (n < 65) begin
      errors++; $display("FAIL sweep_issue_count: got %0d want >=65", n);
    end
    drain();
  endtask

  task automatic test_wrap();
    int exp_a[5] = '{0, 48, 32, 16, 0};
    int n = 0;
    step = 16'hC000;
    drv(0, 1, 0, 0, 1);
    for (int c = 0; c < 20 && n < 5; c++) begin
      drv(0, 0, 0, 1, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (rom_en) begin
        checks++;
        if (rom_addr !== 6'(exp_a[n])) begin
          errors++; $display("FAIL wrap_addr %0d: got %0d want %0d", n, rom_addr, exp_a[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL wrap_issue_count: got %0d want 5", n);
    end
    drain();
  endtask

  task automatic test_stall();
    step = 16'h0400;
    drv(0, 1, 0, 0, 1);
    drv(0, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drv(0, 0, 0, 1, 0);
      checks++;
      if (rom_en !== 1'b0 || sample_valid !== 1'b1 || sample_data !== rom[0]) begin
        errors++;
        $display("FAIL stall_hold %0d: got en=%b v=%b d=%h want en=0 v=1 d=%h",
                 c, rom_en, sample_valid, sample_data, rom[0]);
      end
    end
    drv(0, 0, 0, 0, 1);
    checks++;
    if (overrun !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL stall_overrun: got %h want %h", obs_vec(), exp_vec());
    end
    drv(0, 0, 0, 1, 1);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 6'd1) begin
      errors++; $display("FAIL stall_resume: got en=%b addr=%0d want en=1 addr=1", rom_en, rom_addr);
    end
    drain();
  endtask

  task automatic test_start_stop_idle();
    drv(0, 1, 1, 1, 1);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rom_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL start_stop_idle %0d: got en=%b busy=%b want 0 0", c, rom_en, busy);
      end
      drv(0, 0, 0, 1, 1);
    end
  endtask

  task automatic test_stop_pending();
    step = 16'h0400;
    drv(0, 1, 0, 0, 1);
    drv(0, 0, 0, 1, 1);
    drv(0, 0, 1, 0, 1);
    checks++;
    if (busy !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL stop_pend_busy: got %h want %h", obs_vec(), exp_vec());
    end
    drv(0, 0, 0, 1, 0);
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== rom[0] || busy !== 1'b0 || rom_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_pend_deliver: got v=%b d=%h busy=%b en=%b want v=1 d=%h busy=0 en=0",
               sample_valid, sample_data, busy, rom_en, rom[0]);
    end
    drain();
  endtask

  task automatic test_rst_pending();
    step = 16'h0800;
    drv(0, 1, 0, 0, 1);
    drv(0, 0, 0, 1, 1);
    drv(0, 0, 0, 1, 1);
    drv(1, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 1);
    checks++;
    if (obs_vec() !== 74'd0) begin
      errors++; $display("FAIL rst_pending: got %h want 0", obs_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      step = 16'($urandom);
      drv($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {$urandom, $urandom};
    test_reset();
    test_sweep();
    test_wrap();
    test_stall();
    test_start_stop_idle();
    test_stop_pending();
    test_rst_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
